// File: rtl/sail_core_defines_pkg.sv
// Shared sail-core microarchitecture defines: ALUctl field encodings used by
// both the ALU-control decoder and the ALU.
package sail_core_defines_pkg;

  localparam int unsigned kSAIL_XLEN = 32;

  // ALUctl[3:0]: operation select
  localparam logic [3:0] kSAIL_MICROARCHITECTURE_ALUCTL_3to0_AND   = 4'b0000;
  localparam logic [3:0] kSAIL_MICROARCHITECTURE_ALUCTL_3to0_OR    = 4'b0001;
  localparam logic [3:0] kSAIL_MICROARCHITECTURE_ALUCTL_3to0_ADD   = 4'b0010;
  localparam logic [3:0] kSAIL_MICROARCHITECTURE_ALUCTL_3to0_SRL   = 4'b0011;
  localparam logic [3:0] kSAIL_MICROARCHITECTURE_ALUCTL_3to0_SRA   = 4'b0100;
  localparam logic [3:0] kSAIL_MICROARCHITECTURE_ALUCTL_3to0_XOR   = 4'b0101;
  localparam logic [3:0] kSAIL_MICROARCHITECTURE_ALUCTL_3to0_SUB   = 4'b0110;
  localparam logic [3:0] kSAIL_MICROARCHITECTURE_ALUCTL_3to0_SLT   = 4'b0111;
  localparam logic [3:0] kSAIL_MICROARCHITECTURE_ALUCTL_3to0_SLL   = 4'b1000;
  localparam logic [3:0] kSAIL_MICROARCHITECTURE_ALUCTL_3to0_CSRRW = 4'b1001;
  localparam logic [3:0] kSAIL_MICROARCHITECTURE_ALUCTL_3to0_CSRRS = 4'b1010;
  localparam logic [3:0] kSAIL_MICROARCHITECTURE_ALUCTL_3to0_CSRRC = 4'b1011;
  localparam logic [3:0] kSAIL_MICROARCHITECTURE_ALUCTL_3to0_SLTU  = 4'b1100;

  // ALUctl[6:4]: branch comparison select (000 and 111 mean "not a branch")
  localparam logic [2:0] kSAIL_MICROARCHITECTURE_ALUCTL_6to4_BEQ  = 3'b001;
  localparam logic [2:0] kSAIL_MICROARCHITECTURE_ALUCTL_6to4_BNE  = 3'b010;
  localparam logic [2:0] kSAIL_MICROARCHITECTURE_ALUCTL_6to4_BLT  = 3'b011;
  localparam logic [2:0] kSAIL_MICROARCHITECTURE_ALUCTL_6to4_BGE  = 3'b100;
  localparam logic [2:0] kSAIL_MICROARCHITECTURE_ALUCTL_6to4_BLTU = 3'b101;
  localparam logic [2:0] kSAIL_MICROARCHITECTURE_ALUCTL_6to4_BGEU = 3'b110;

endpackage

// File: rtl/alu_branch_cmp.sv
// Combinational branch comparator: evaluates the condition selected by
// ALUctl[6:4] on operands A and B.
module alu_branch_cmp
  import sail_core_defines_pkg::*;
(
  input  logic [kSAIL_XLEN-1:0] a,
  input  logic [kSAIL_XLEN-1:0] b,
  input  logic [2:0]            br_sel,
  output logic                  taken
);

  logic eq;
  logic lt_s;
  logic lt_u;

  assign eq   = (a == b);
  assign lt_s = ($signed(a) < $signed(b));
  assign lt_u = (a < b);

  always_comb begin
    // NOTE: default assigned first so every path drives taken; no latch is inferred.
    taken = 1'b0;
    case (br_sel)
      kSAIL_MICROARCHITECTURE_ALUCTL_6to4_BEQ:  taken = eq;
      kSAIL_MICROARCHITECTURE_ALUCTL_6to4_BNE:  taken = ~eq;
      kSAIL_MICROARCHITECTURE_ALUCTL_6to4_BLT:  taken = lt_s;
      kSAIL_MICROARCHITECTURE_ALUCTL_6to4_BGE:  taken = ~lt_s;
      kSAIL_MICROARCHITECTURE_ALUCTL_6to4_BLTU: taken = lt_u;
      kSAIL_MICROARCHITECTURE_ALUCTL_6to4_BGEU: taken = ~lt_u;
      default:                                  taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu.sv
// Registered 32-bit RV32I ALU with branch-taken flag, one-cycle latency.
// Define SAIL_ALU_CSR_OPS_EN to enable the CSRRW/CSRRS/CSRRC operation codes.
module alu
  import sail_core_defines_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            ALUctl,
  input  logic [kSAIL_XLEN-1:0] A,
  input  logic [kSAIL_XLEN-1:0] B,
  output logic [kSAIL_XLEN-1:0] ALUOut,
  output logic                  Branch_Enable
);

  logic [kSAIL_XLEN-1:0] alu_out_d, alu_out_q;
  logic                  branch_en_d, branch_en_q;
  logic [4:0]            shamt;

  assign shamt = B[4:0];

  alu_branch_cmp u_branch_cmp (
    .a      (A),
    .b      (B),
    .br_sel (ALUctl[6:4]),
    .taken  (branch_en_d)
  );

  always_comb begin
    alu_out_d = '0;
    case (ALUctl[3:0])
      kSAIL_MICROARCHITECTURE_ALUCTL_3to0_AND:  alu_out_d = A & B;
      kSAIL_MICROARCHITECTURE_ALUCTL_3to0_OR:   alu_out_d = A | B;
      kSAIL_MICROARCHITECTURE_ALUCTL_3to0_ADD:  alu_out_d = A + B;
      kSAIL_MICROARCHITECTURE_ALUCTL_3to0_SRL:  alu_out_d = A >> shamt;
      kSAIL_MICROARCHITECTURE_ALUCTL_3to0_SRA:  alu_out_d = kSAIL_XLEN'($signed(A) >>> shamt);
      kSAIL_MICROARCHITECTURE_ALUCTL_3to0_XOR:  alu_out_d = A ^ B;
      kSAIL_MICROARCHITECTURE_ALUCTL_3to0_SUB:  alu_out_d = A - B;
      kSAIL_MICROARCHITECTURE_ALUCTL_3to0_SLT:  alu_out_d = {31'b0, $signed(A) < $signed(B)};
      kSAIL_MICROARCHITECTURE_ALUCTL_3to0_SLL:  alu_out_d = A << shamt;
      kSAIL_MICROARCHITECTURE_ALUCTL_3to0_SLTU: alu_out_d = {31'b0, A < B};
`ifdef SAIL_ALU_CSR_OPS_EN
      kSAIL_MICROARCHITECTURE_ALUCTL_3to0_CSRRW: alu_out_d = A;
      kSAIL_MICROARCHITECTURE_ALUCTL_3to0_CSRRS: alu_out_d = A | B;
      kSAIL_MICROARCHITECTURE_ALUCTL_3to0_CSRRC: alu_out_d = ~A & B;
`endif
      default:                                  alu_out_d = '0;
    endcase
  end

  // NOTE: only these two output flops are reset; the async clear discards any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_out_q   <= '0;
      branch_en_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values.
      alu_out_q   <= alu_out_d;
      branch_en_q <= branch_en_d;
    end
  end

  assign ALUOut        = alu_out_q;
  assign Branch_Enable = branch_en_q;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the registered ALU: reset behaviour,
// operations, shifts, compares, branches and the optional CSR codes.
module tb_alu;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [6:0]  alu_ctl = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] alu_out;
  logic        branch_en;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ALUctl        (alu_ctl),
    .A             (a),
    .B             (b),
    .ALUOut        (alu_out),
    .Branch_Enable (branch_en)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Apply inputs mid-cycle, let one rising edge capture them, sample 1ns later.
  task automatic step(input logic [2:0] br, input logic [3:0] op,
                      input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    alu_ctl = {br, op};
    a       = av;
    b       = bv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset asserted with no clock edge: outputs clear immediately.
    alu_ctl = {3'b010, 4'b0010};
    a       = 32'h1234_5678;
    b       = 32'h0000_0001;
    #1 rst_n = 1'b0;
    #2;
    check("rst_async_out", alu_out, 32'h0);
    check("rst_async_br", {31'b0, branch_en}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_out", alu_out, 32'h0);
    check("rst_hold_br", {31'b0, branch_en}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_release_add", alu_out, 32'h1234_5679);
    check("rst_release_bne", {31'b0, branch_en}, 32'h1);

    // Logic / arithmetic
    step(3'b000, 4'b0000, 32'h0F, 32'h55);         check("and", alu_out, 32'h05);
    step(3'b000, 4'b0001, 32'h0F, 32'h55);         check("or", alu_out, 32'h5F);
    step(3'b000, 4'b0101, 32'h0F, 32'h55);         check("xor", alu_out, 32'h5A);
    step(3'b000, 4'b0010, 32'hFFFF_FFFF, 32'h1);   check("add_wrap", alu_out, 32'h0);
    step(3'b000, 4'b0010, 32'd100, 32'd23);        check("add", alu_out, 32'd123);
    step(3'b000, 4'b0110, 32'h0, 32'h1);           check("sub_wrap", alu_out, 32'hFFFF_FFFF);
    step(3'b000, 4'b0110, 32'd50, 32'd8);          check("sub", alu_out, 32'd42);

    // Shifts
    step(3'b000, 4'b0011, 32'h8000_0010, 32'h24);  check("srl_upper_b_ignored", alu_out, 32'h0800_0001);
    step(3'b000, 4'b0100, 32'h8000_0010, 32'h4);   check("sra", alu_out, 32'hF800_0001);
    step(3'b000, 4'b0100, 32'h4000_0010, 32'h4);   check("sra_pos", alu_out, 32'h0400_0001);
    step(3'b000, 4'b1000, 32'h8000_0010, 32'h4);   check("sll", alu_out, 32'h0000_0100);
    step(3'b000, 4'b1000, 32'h8000_0010, 32'h20);  check("sll_by_0", alu_out, 32'h8000_0010);
    step(3'b000, 4'b0011, 32'h8000_0010, 32'h0);   check("srl_by_0", alu_out, 32'h8000_0010);

    // Compares (ALU result and branch flag in the same cycle)
    step(3'b011, 4'b0111, 32'h8000_0000, 32'h0);
    check("slt_neg", alu_out, 32'h1);
    check("blt_neg", {31'b0, branch_en}, 32'h1);
    step(3'b110, 4'b1100, 32'h8000_0000, 32'h0);
    check("sltu_big", alu_out, 32'h0);
    check("bgeu_big", {31'b0, branch_en}, 32'h1);
    step(3'b000, 4'b1100, 32'h0, 32'h8000_0000);   check("sltu_lt", alu_out, 32'h1);

    // Branches
    step(3'b001, 4'b0000, 32'h0F, 32'h55);         check("beq_ne", {31'b0, branch_en}, 32'h0);
    step(3'b001, 4'b0000, 32'h55, 32'h55);         check("beq_eq", {31'b0, branch_en}, 32'h1);
    step(3'b010, 4'b0000, 32'h0E, 32'h55);         check("bne", {31'b0, branch_en}, 32'h1);
    step(3'b011, 4'b0000, 32'd10000, 32'd111);     check("blt", {31'b0, branch_en}, 32'h0);
    step(3'b100, 4'b0000, 32'd10000, 32'd111);     check("bge", {31'b0, branch_en}, 32'h1);
    step(3'b100, 4'b0000, 32'hFFFF_FFFF, 32'h1);   check("bge_neg", {31'b0, branch_en}, 32'h0);
    step(3'b101, 4'b0000, 32'h0, 32'h2);           check("bltu", {31'b0, branch_en}, 32'h1);
    step(3'b110, 4'b0000, 32'd16, 32'd2);          check("bgeu", {31'b0, branch_en}, 32'h1);
    step(3'b100, 4'b0000, 32'h7, 32'h7);           check("bge_eq", {31'b0, branch_en}, 32'h1);
    step(3'b110, 4'b0000, 32'h7, 32'h7);           check("bgeu_eq", {31'b0, branch_en}, 32'h1);
    step(3'b111, 4'b0000, 32'h7, 32'h7);           check("br_111", {31'b0, branch_en}, 32'h0);
    step(3'b000, 4'b0000, 32'h7, 32'h7);           check("br_000", {31'b0, branch_en}, 32'h0);

    // Unlisted operation codes
    step(3'b000, 4'b1101, 32'hF0, 32'h3C);         check("op_1101", alu_out, 32'h0);
    step(3'b000, 4'b1111, 32'hF0, 32'h3C);         check("op_1111", alu_out, 32'h0);

    // CSR codes
`ifdef SAIL_ALU_CSR_OPS_EN
    step(3'b000, 4'b1001, 32'hF0, 32'h3C);         check("csrrw", alu_out, 32'hF0);
    step(3'b000, 4'b1010, 32'hF0, 32'h3C);         check("csrrs", alu_out, 32'hFC);
    step(3'b000, 4'b1011, 32'hF0, 32'h3C);         check("csrrc", alu_out, 32'h0C);
`else
    step(3'b000, 4'b1001, 32'hF0, 32'h3C);         check("csrrw_off", alu_out, 32'h0);
    step(3'b000, 4'b1010, 32'hF0, 32'h3C);         check("csrrs_off", alu_out, 32'h0);
    step(3'b000, 4'b1011, 32'hF0, 32'h3C);         check("csrrc_off", alu_out, 32'h0);
`endif

    // Mid-stream reset between edges discards the registered result.
    step(3'b010, 4'b0010, 32'd5, 32'd3);
    check("pre_rst_out", alu_out, 32'd8);
    check("pre_rst_br", {31'b0, branch_en}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out", alu_out, 32'h0);
    check("mid_rst_br", {31'b0, branch_en}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(3'b000, 4'b0110, 32'd9, 32'd4);           check("post_rst_sub", alu_out, 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
